// File: rtl/ring_mod_pipe_if.sv
// Sample/control bus for ring_mod_pipe: the stereo sample pair with its strobe,
// the carrier controls, and the delayed stereo result with its valid strobe.
interface ring_mod_pipe_if #(
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 24,
    parameter int MIX_W    = 8
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] left_in;
    logic signed [SAMPLE_W-1:0] right_in;
    logic [PHASE_W-1:0]         phase_inc;
    logic                       phase_clr;
    logic [1:0]                 mode;
    logic [MIX_W:0]             depth;
    logic signed [SAMPLE_W-1:0] left_out;
    logic signed [SAMPLE_W-1:0] right_out;
    logic                       out_valid;

    modport master (
        output sample_valid, left_in, right_in, phase_inc, phase_clr, mode, depth,
        input  left_out, right_out, out_valid
    );

    modport slave (
        input  sample_valid, left_in, right_in, phase_inc, phase_clr, mode, depth,
        output left_out, right_out, out_valid
    );
endinterface

// File: rtl/ring_mod_pipe.sv
// Stereo ring/AM modulator with an internal phase-accumulator carrier.
// Registers: capture+carrier, product, saturated wet, wet/dry mix (3-cycle latency).
module ring_mod_pipe #(
    parameter int SAMPLE_W  = 16,
    parameter int CARRIER_W = 16,
    parameter int PHASE_W   = 24,
    parameter int MIX_W     = 8
) (
    input  logic           clk,
    input  logic           reset,
    ring_mod_pipe_if.slave bus
);
    localparam int PW = SAMPLE_W + CARRIER_W;
    localparam int XW = SAMPLE_W + MIX_W + 2;

    localparam logic [CARRIER_W-1:0] HALF    = CARRIER_W'(1) << (CARRIER_W - 1);
    localparam logic [CARRIER_W-1:0] QUARTER = CARRIER_W'(1) << (CARRIER_W - 2);
    localparam logic [CARRIER_W-1:0] CMAX    = HALF - CARRIER_W'(1);
    localparam logic [MIX_W:0]       FULL    = (MIX_W + 1)'(1) << MIX_W;
    localparam logic signed [PW-1:0] SAT_HI  = (PW'(1) <<< (SAMPLE_W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_LO  = ~SAT_HI;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'b00,
        MODE_RING_TRI = 2'b01,
        MODE_RING_SQR = 2'b10,
        MODE_AM       = 2'b11
    } mode_e;

    function automatic logic signed [SAMPLE_W-1:0] sat_wet(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> (CARRIER_W - 1);
        if (s > SAT_HI)      s = SAT_HI;
        else if (s < SAT_LO) s = SAT_LO;
        return SAMPLE_W'(s);
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] mix(
        input logic signed [SAMPLE_W-1:0] dry,
        input logic signed [SAMPLE_W-1:0] wet,
        input logic [MIX_W:0]             d,
        input mode_e                      m
    );
        logic signed [XW-1:0] wd;
        logic signed [XW-1:0] sum;
        wd  = XW'($signed({1'b0, d}));
        sum = XW'(dry) * (XW'($signed({1'b0, FULL})) - wd) + XW'(wet) * wd;
        if (m == MODE_BYPASS) return dry;
        return SAMPLE_W'(sum >>> MIX_W);
    endfunction

    // Carrier generation from the phase the current sample will use
    logic [PHASE_W-1:0]          acc;
    logic [PHASE_W-1:0]          phase_now;
    logic [CARRIER_W-1:0]        u;
    logic [CARRIER_W-2:0]        fold;
    logic signed [CARRIER_W-1:0] tri_c;
    logic signed [CARRIER_W-1:0] sqr_c;
    logic signed [CARRIER_W-1:0] am_c;
    logic signed [CARRIER_W-1:0] car;
    logic [MIX_W:0]              depth_clamped;
    mode_e                       mode_in;

    always_comb begin
        mode_in       = mode_e'(bus.mode);
        phase_now     = bus.phase_clr ? '0 : acc;
        u             = phase_now[PHASE_W-1 -: CARRIER_W];
        fold          = u[CARRIER_W-1] ? ~u[CARRIER_W-2:0] : u[CARRIER_W-2:0];
        tri_c         = $signed({fold, 1'b0} - HALF);
        sqr_c         = u[CARRIER_W-1] ? $signed(CARRIER_W'(0) - CMAX) : $signed(CMAX);
        am_c          = (tri_c >>> 1) + $signed(QUARTER);
        depth_clamped = (bus.depth > FULL) ? FULL : bus.depth;
        case (mode_in)
            MODE_RING_SQR: car = sqr_c;
            MODE_AM:       car = am_c;
            default:       car = tri_c;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 acc <= '0;
        else if (bus.sample_valid) acc <= phase_now + bus.phase_inc;
        else if (bus.phase_clr)    acc <= '0;
    end

    logic                        v1, v2, v3;
    logic signed [SAMPLE_W-1:0]  l1, r1;
    logic signed [CARRIER_W-1:0] c1;
    mode_e                       m1, m2, m3;
    logic [MIX_W:0]              d1, d2, d3;
    logic signed [PW-1:0]        pl2, pr2;
    logic signed [SAMPLE_W-1:0]  dl2, dr2, dl3, dr3, wl3, wr3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0; l1 <= '0; r1 <= '0; c1 <= '0; m1 <= MODE_BYPASS; d1 <= '0;
            v2 <= 1'b0; pl2 <= '0; pr2 <= '0; dl2 <= '0; dr2 <= '0; m2 <= MODE_BYPASS; d2 <= '0;
            v3 <= 1'b0; wl3 <= '0; wr3 <= '0; dl3 <= '0; dr3 <= '0; m3 <= MODE_BYPASS; d3 <= '0;
            bus.out_valid <= 1'b0;
            bus.left_out  <= '0;
            bus.right_out <= '0;
        end else begin
            v1 <= bus.sample_valid;
            if (bus.sample_valid) begin
                l1 <= bus.left_in;
                r1 <= bus.right_in;
                c1 <= car;
                m1 <= mode_in;
                d1 <= depth_clamped;
            end
            v2 <= v1;
            if (v1) begin
                pl2 <= PW'(l1) * PW'(c1);
                pr2 <= PW'(r1) * PW'(c1);
                dl2 <= l1;
                dr2 <= r1;
                m2  <= m1;
                d2  <= d1;
            end
            v3 <= v2;
            if (v2) begin
                wl3 <= (m2 == MODE_BYPASS) ? dl2 : sat_wet(pl2);
                wr3 <= (m2 == MODE_BYPASS) ? dr2 : sat_wet(pr2);
                dl3 <= dl2;
                dr3 <= dr2;
                m3  <= m2;
                d3  <= d2;
            end
            bus.out_valid <= v3;
            if (v3) begin
                bus.left_out  <= mix(dl3, wl3, d3, m3);
                bus.right_out <= mix(dr3, wr3, d3, m3);
            end
        end
    end
endmodule

// File: tb/tb_ring_mod_pipe.sv
// Bench for ring_mod_pipe: directed cases plus a randomized stream checked
// cycle by cycle against an arithmetic model of the modulator.
module tb_ring_mod_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ntests = 0;
    int   nfail = 0;
    int   cyc = 0;

    ring_mod_pipe_if #(.SAMPLE_W(16), .PHASE_W(24), .MIX_W(8)) bus ();

    ring_mod_pipe #(.SAMPLE_W(16), .CARRIER_W(16), .PHASE_W(24), .MIX_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int l;
        int r;
    } exp_t;

    exp_t        q[$];
    int unsigned phase = 0;
    int          held_l = 0;
    int          held_r = 0;

    task automatic chk(input string tag, input integer obs, input integer exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int carrier(input int unsigned ph, input int md);
        int u, tri_v;
        u     = int'(ph >> 8);
        tri_v = (u < 32768) ? 2 * u - 32768 : 2 * (65535 - u) - 32768;
        if (md == 2) return (u < 32768) ? 32767 : -32767;
        if (md == 3) return (tri_v >>> 1) + 16384;
        return tri_v;
    endfunction

    function automatic int ref_out(input int s, input int unsigned ph, input int md, input int dp);
        longint w, m;
        int d;
        if (md == 0) return s;
        d = (dp > 256) ? 256 : dp;
        w = (longint'(s) * carrier(ph, md)) >>> 15;
        if (w > 32767) w = 32767;
        if (w < -32768) w = -32768;
        m = (longint'(s) * (256 - d) + w * d) >>> 8;
        return int'(m);
    endfunction

    task automatic step(input bit v, input int l, input int r, input int unsigned inc,
                        input bit clr, input int md, input int dp);
        int unsigned ph;
        exp_t e;
        bus.sample_valid = v;
        bus.left_in      = l[15:0];
        bus.right_in     = r[15:0];
        bus.phase_inc    = inc[23:0];
        bus.phase_clr    = clr;
        bus.mode         = md[1:0];
        bus.depth        = dp[8:0];
        @(posedge clk);
        cyc++;
        ph = clr ? 0 : phase;
        if (v) begin
            e.due = cyc + 3;
            e.l   = ref_out(l, ph, md & 3, dp & 511);
            e.r   = ref_out(r, ph, md & 3, dp & 511);
            q.push_back(e);
            phase = (ph + (inc & 24'hFFFFFF)) & 24'hFFFFFF;
        end else if (clr) begin
            phase = 0;
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            held_l = q[0].l;
            held_r = q[0].r;
            void'(q.pop_front());
            chk("out_valid_hi", bus.out_valid, 1);
        end else begin
            chk("out_valid_lo", bus.out_valid, 0);
        end
        chk("left_out", bus.left_out, held_l);
        chk("right_out", bus.right_out, held_r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic one(input string tag, input int l, input int r, input int unsigned inc,
                       input bit clr, input int md, input int dp, input int el, input int er);
        step(1'b1, l, r, inc, clr, md, dp);
        idle(3);
        chk({tag, "_l"}, bus.left_out, el);
        chk({tag, "_r"}, bus.right_out, er);
    endtask

    int wrapv[5];

    initial begin
        bus.sample_valid = 1'b0;
        bus.left_in = '0;
        bus.right_in = '0;
        bus.phase_inc = '0;
        bus.phase_clr = 1'b0;
        bus.mode = '0;
        bus.depth = '0;
        wrapv = '{-16384, 0, 16383, -1, -16384};

        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_left", bus.left_out, 0);
        chk("reset_right", bus.right_out, 0);
        #1 reset = 1'b0;

        one("square", 1000, -1000, 0, 1'b0, 2, 256, 999, -1000);
        one("tri_sat", -32768, -32768, 0, 1'b1, 1, 256, 32767, 32767);
        one("mix_half", 1000, 1000, 0, 1'b1, 2, 128, 999, 999);
        one("depth_clamp", 1000, -1000, 0, 1'b1, 2, 511, 999, -1000);
        one("bypass", 12345, -12345, 0, 1'b0, 0, 37, 12345, -12345);
        one("am_ph0", 20000, -20000, 24'h800000, 1'b1, 3, 256, 0, 0);
        one("am_ph_half", 20000, -20000, 0, 1'b0, 3, 256, 19999, -20000);

        for (int i = 0; i < 8; i++) begin
            step(i < 5, 16384, 16384, 24'h400000, i == 0, 1, 256);
            if (i >= 3) chk("wrap", bus.left_out, wrapv[i-3]);
        end

        // back-to-back samples with a mode change between them
        step(1'b1, 10000, 10000, 0, 1'b1, 2, 256);
        step(1'b1, 10000, 10000, 0, 1'b0, 1, 256);
        idle(2);
        chk("mode_first", bus.left_out, 9999);
        idle(1);
        chk("mode_second", bus.left_out, -10000);

        for (int i = 0; i < 120; i++) begin
            int l, r, md, dp;
            bit v, clr;
            l   = int'($urandom_range(65535, 0)) - 32768;
            r   = ($urandom_range(7, 0) == 0) ? -32768 : int'($urandom_range(65535, 0)) - 32768;
            md  = int'($urandom_range(3, 0));
            dp  = int'($urandom_range(300, 0));
            v   = ($urandom_range(9, 0) < 7);
            clr = ($urandom_range(9, 0) == 0);
            step(v, l, r, $urandom_range(24'hFFFFFF, 0), clr, md, dp);
        end

        // reset with samples in flight
        step(1'b1, 5000, 6000, 24'h123456, 1'b0, 1, 200);
        step(1'b1, 7000, 8000, 24'h123456, 1'b0, 2, 100);
        step(1'b1, 9000, 1000, 24'h123456, 1'b0, 3, 256);
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_left", bus.left_out, 0);
        chk("midrst_right", bus.right_out, 0);
        q.delete();
        held_l = 0;
        held_r = 0;
        phase = 0;
        @(posedge clk);
        cyc++;
        #2 reset = 1'b0;
        idle(4);
        step(1'b1, 16384, -16384, 24'h400000, 1'b0, 1, 256);
        idle(2);
        chk("post_rst_lat", bus.out_valid, 0);
        idle(1);
        chk("post_rst_l", bus.left_out, -16384);
        chk("post_rst_r", bus.right_out, 16384);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
